spawn_generator: RTL



---
 rtl/spawn_pkg.sv | 31 +++
 rtl/lfsr24.sv | 19 +
 rtl/spawn_generator.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spawn_pkg.sv
// Shared types and constants for the spawn generator: FSM states, LFSR
// polynomial, LFSR field positions and the seed fallback.
package spawn_pkg;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      DRAW  = 2'd1,
      OFFER = 2'd2
   } state_t;

   localparam int                LFSR_W        = 24;
   localparam logic [LFSR_W-1:0] LFSR_MASK     = 24'hE10000;
   localparam logic [LFSR_W-1:0] SEED_FALLBACK = 24'hACE1;

   localparam int CH_LSB      = 10;
   localparam int CH_MSB      = 14;
   localparam int SPD_LSB     = 15;
   localparam int SPD_MSB     = 18;
   localparam int CH_FIELD_W  = CH_MSB - CH_LSB + 1;
   localparam int SPD_FIELD_W = SPD_MSB - SPD_LSB + 1;

   // An all-zero seed would lock a Galois LFSR at zero forever.
   function automatic logic [LFSR_W-1:0] safe_seed(input logic [LFSR_W-1:0] s);
      return (s == '0) ? SEED_FALLBACK : s;
   endfunction

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction

endpackage

// File: rtl/lfsr24.sv
// Free-running 24-bit Galois LFSR; loads the seed while reset is held and
// advances once per clock otherwise.
module lfsr24
   import spawn_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] q
);

   // NOTE: registers are written with non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst_n) q <= seed;
      else        q <= lfsr_step(q);
   end

endmodule

// File: rtl/spawn_generator.sv
// Spawn-record source: level-scaled interval timer, bounded rejection sampler
// and valid/ready offer. Optional macro GEN_NO_REPEAT_EN blocks repeated chars.
module spawn_generator
   import spawn_pkg::*;
#(
   parameter int                SCREEN_W      = 640,
   parameter int                Y_W           = 10,
   parameter int                X_W           = 9,
   parameter int                CH_BASE       = 97,
   parameter int                CH_RANGE      = 26,
   parameter int                BASE_INTERVAL = 50_000_000,
   parameter int                MAX_TRIES     = 4,
   parameter logic [LFSR_W-1:0] SEED          = 24'h5A5A5A
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           enable,
   input  logic [2:0]     level,
   output logic           spawn_valid,
   input  logic           spawn_ready,
   output logic [7:0]     ch,
   output logic [3:0]     speed,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y
);

   localparam int                   TIMER_W  = $clog2(BASE_INTERVAL + 1);
   localparam int                   ATT_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TIMER_W-1:0]   BASE_T   = TIMER_W'(BASE_INTERVAL);
   localparam logic [ATT_W-1:0]     LAST_ATT = ATT_W'(MAX_TRIES - 1);
   localparam logic [Y_W:0]         Y_LIM    = (Y_W + 1)'(SCREEN_W);
   localparam logic [CH_FIELD_W:0]  CH_LIM   = (CH_FIELD_W + 1)'(CH_RANGE);
   localparam logic [7:0]           CH_BASE8 = 8'(CH_BASE);
   localparam logic [LFSR_W-1:0]    SEED_EFF = safe_seed(SEED);

   state_t                 state;
   logic [TIMER_W-1:0]     timer;
   logic [TIMER_W-1:0]     reload;
   logic [ATT_W-1:0]       attempt;
   logic [LFSR_W-1:0]      lfsr_q;
   logic [Y_W-1:0]         ycand;
   logic [Y_W-1:0]         y_fold;
   logic [CH_FIELD_W-1:0]  chcand;
   logic [CH_FIELD_W-1:0]  chidx_draw;
   logic [CH_FIELD_W-1:0]  chidx_sel;
   logic [SPD_FIELD_W-1:0] sraw;
   logic [SPD_FIELD_W-1:0] speed_next;
   logic                   accept;
   logic                   unused_lfsr_bits;

   lfsr24 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (SEED_EFF),
      .q     (lfsr_q)
   );

   assign ycand            = lfsr_q[Y_W-1:0];
   assign chcand           = lfsr_q[CH_MSB:CH_LSB];
   assign sraw             = lfsr_q[SPD_MSB:SPD_LSB];
   assign unused_lfsr_bits = ^lfsr_q[LFSR_W-1:SPD_MSB+1];
   assign x                = '0;

   // The final attempt is taken unconditionally; folding then pulls it in range.
   assign accept = (({1'b0, ycand} < Y_LIM) && ({1'b0, chcand} < CH_LIM))
                 || (attempt == LAST_ATT);

   always_comb begin : fold_p
      logic [Y_W:0]        yv;
      logic [CH_FIELD_W:0] cv;
      // NOTE: each variable is given a value before any branch, so no path
      // can leave it holding state and infer a latch.
      yv = {1'b0, ycand};
      if (yv >= Y_LIM) yv = yv - Y_LIM;
      if (yv >= Y_LIM) yv = yv - Y_LIM;
      y_fold = yv[Y_W-1:0];
      cv = {1'b0, chcand};
      for (int i = 0; i < (1 << CH_FIELD_W); i++) begin
         if (cv >= CH_LIM) cv = cv - CH_LIM;
      end
      chidx_draw = cv[CH_FIELD_W-1:0];
   end

   always_comb begin : speed_p
      logic [SPD_FIELD_W:0] floor_v;
      logic [SPD_FIELD_W:0] raw_v;
      logic [SPD_FIELD_W:0] pick;
      floor_v    = (SPD_FIELD_W + 1)'(level) + (SPD_FIELD_W + 1)'(1);
      raw_v      = {1'b0, sraw};
      pick       = (raw_v > floor_v) ? raw_v : floor_v;
      speed_next = pick[SPD_FIELD_W] ? '1 : pick[SPD_FIELD_W-1:0];
   end

   // Interval is max(BASE >> level, 1); the timer counts interval-1 down to 0.
   always_comb begin : reload_p
      logic [TIMER_W-1:0] shifted;
      shifted = BASE_T >> level;
      reload  = (shifted == '0) ? '0 : shifted - TIMER_W'(1);
   end

`ifdef GEN_NO_REPEAT_EN
   localparam logic [CH_FIELD_W-1:0] CH_TOP = CH_FIELD_W'(CH_RANGE - 1);

   logic [CH_FIELD_W-1:0] last_chidx;
   logic [CH_FIELD_W-1:0] chidx_q;

   always_comb begin
      chidx_sel = chidx_draw;
      if ((CH_RANGE > 1) && (chidx_draw == last_chidx))
         chidx_sel = (chidx_draw == CH_TOP) ? '0 : chidx_draw + CH_FIELD_W'(1);
   end

   // History only advances on a completed handshake; a dropped offer never counts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_chidx <= CH_TOP;
         chidx_q    <= '0;
      end else begin
         if (state == DRAW && accept)        chidx_q    <= chidx_sel;
         if (state == OFFER && spawn_ready)  last_chidx <= chidx_q;
      end
   end
`else
   assign chidx_sel = chidx_draw;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= WAIT;
         timer       <= BASE_T - TIMER_W'(1);
         attempt     <= '0;
         spawn_valid <= 1'b0;
         ch          <= CH_BASE8;
         speed       <= 4'd1;
         y           <= '0;
      end else begin
         case (state)
            WAIT: begin
               if (enable) begin
                  if (timer == '0) state <= DRAW;
                  else             timer <= timer - TIMER_W'(1);
               end
            end
            DRAW: begin
               if (accept) begin
                  attempt     <= '0;
                  ch          <= CH_BASE8 + 8'(chidx_sel);
                  speed       <= speed_next;
                  y           <= y_fold;
                  spawn_valid <= 1'b1;
                  state       <= OFFER;
               end else begin
                  attempt <= attempt + ATT_W'(1);
               end
            end
            OFFER: begin
               if (spawn_ready) begin
                  spawn_valid <= 1'b0;
                  timer       <= reload;
                  state       <= WAIT;
               end
            end
            default: state <= WAIT;
         endcase
      end
   end

endmodule
